// File: rtl/stutter_sync_scheduler.sv
// rtl/stutter_sync_scheduler.sv - aligns observable events of two program copies by stalling the one that runs ahead
// Stutter outputs are Mealy-decoded so a stall lands on the same edge that samples the event.
module stutter_sync_scheduler #(
   parameter int MAX_STALL = 8,
   parameter int CW        = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ev_s,
   input  logic          ev_t,
   input  logic          done_s,
   input  logic          done_t,
   input  logic [1:0]    choice,
   output logic          stutter_s,
   output logic          stutter_t,
   output logic          sync_pulse,
   output logic          timeout,
   output logic          all_done,
   output logic [CW-1:0] stall_cnt
);

   typedef enum logic [1:0] {RUN, WAIT_T, WAIT_S, DONE} state_t;

   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_STALL);
   localparam logic [CW-1:0] ONE     = CW'(1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_d;
   logic          sync_d, timeout_d;
   logic          ev_s_eff, ev_t_eff;

   // A terminated copy counts as permanently caught up.
   assign ev_s_eff = ev_s | done_s;
   assign ev_t_eff = ev_t | done_t;

   always_comb begin
      state_d   = state_q;
      cnt_d     = stall_cnt;
      sync_d    = 1'b0;
      timeout_d = timeout;
      stutter_s = 1'b0;
      stutter_t = 1'b0;
      case (state_q)
         RUN: begin
            if (done_s && done_t) begin
               state_d   = DONE;
               stutter_s = 1'b1;
               stutter_t = 1'b1;
            end else if (ev_s && ev_t) begin
               sync_d = 1'b1;
            end else if (ev_s && !ev_t_eff) begin
               stutter_s = 1'b1;
               state_d   = WAIT_T;
               cnt_d     = ONE;
            end else if (ev_t && !ev_s_eff) begin
               stutter_t = 1'b1;
               state_d   = WAIT_S;
               cnt_d     = ONE;
            end else if (!ev_s && !ev_t) begin
               stutter_s = choice[0] & ~choice[1] & ~done_s;
               stutter_t = choice[1] & ~choice[0] & ~done_t;
            end
         end
         WAIT_T: begin
            stutter_s = 1'b1;
            if (ev_t) begin
               state_d = RUN;
               sync_d  = 1'b1;
               cnt_d   = '0;
            end else if (done_t) begin
               state_d = RUN;
               cnt_d   = '0;
            end else if (stall_cnt == MAX_CNT) begin
               timeout_d = 1'b1;
               state_d   = RUN;
               cnt_d     = '0;
            end else begin
               cnt_d = stall_cnt + ONE;
            end
         end
         WAIT_S: begin
            stutter_t = 1'b1;
            if (ev_s) begin
               state_d = RUN;
               sync_d  = 1'b1;
               cnt_d   = '0;
            end else if (done_s) begin
               state_d = RUN;
               cnt_d   = '0;
            end else if (stall_cnt == MAX_CNT) begin
               timeout_d = 1'b1;
               state_d   = RUN;
               cnt_d     = '0;
            end else begin
               cnt_d = stall_cnt + ONE;
            end
         end
         DONE: begin
            stutter_s = 1'b1;
            stutter_t = 1'b1;
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase
      // Hold both copies while reset is asserted.
      if (!rst_n) begin
         stutter_s = 1'b1;
         stutter_t = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= RUN;
         stall_cnt  <= '0;
         sync_pulse <= 1'b0;
         timeout    <= 1'b0;
         all_done   <= 1'b0;
      end else begin
         state_q    <= state_d;
         stall_cnt  <= cnt_d;
         sync_pulse <= sync_d;
         timeout    <= timeout_d;
         all_done   <= (state_d == DONE);
      end
   end

endmodule

// File: tb/tb_stutter_sync_scheduler.sv
// tb/tb_stutter_sync_scheduler.sv - self-checking bench for stutter_sync_scheduler
module tb_stutter_sync_scheduler;

   localparam int MAX = 8;
   localparam int CW  = 4;

   logic          clk = 1'b0;
   logic          rst_n, ev_s, ev_t, done_s, done_t;
   logic [1:0]    choice;
   logic          stutter_s, stutter_t, sync_pulse, timeout, all_done;
   logic [CW-1:0] stall_cnt;

   stutter_sync_scheduler #(.MAX_STALL(MAX), .CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .ev_s(ev_s), .ev_t(ev_t),
      .done_s(done_s), .done_t(done_t), .choice(choice),
      .stutter_s(stutter_s), .stutter_t(stutter_t), .sync_pulse(sync_pulse),
      .timeout(timeout), .all_done(all_done), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // Reference model: which copy is held (0 none, 1 source, 2 target) and for how long.
   int m_held = 0, m_age = 0;
   bit m_fin = 0, m_to = 0, m_sync = 0, m_all = 0;
   bit cur_ss, cur_st, pred_ss, pred_st;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic step(input bit r, input bit es, input bit et, input bit ds, input bit dt, input bit [1:0] ch);
      bit o_ev, o_done;
      @(negedge clk);
      rst_n = r; ev_s = es; ev_t = et; done_s = ds; done_t = dt; choice = ch;
      #1;
      cur_ss = stutter_s;
      cur_st = stutter_t;
      if (!r || m_fin) begin
         pred_ss = 1; pred_st = 1;
      end else if (m_held == 1) begin
         pred_ss = 1; pred_st = 0;
      end else if (m_held == 2) begin
         pred_ss = 0; pred_st = 1;
      end else if (ds && dt) begin
         pred_ss = 1; pred_st = 1;
      end else if (es && !(et || dt) && !(es && et)) begin
         pred_ss = 1; pred_st = 0;
      end else if (et && !(es || ds)) begin
         pred_ss = 0; pred_st = 1;
      end else if (!es && !et) begin
         pred_ss = (ch == 2'b01) && !ds;
         pred_st = (ch == 2'b10) && !dt;
      end else begin
         pred_ss = 0; pred_st = 0;
      end
      @(posedge clk);
      if (!r) begin
         m_held = 0; m_age = 0; m_fin = 0; m_to = 0; m_sync = 0; m_all = 0;
      end else begin
         m_sync = 0;
         if (m_fin) begin
            // terminal: nothing moves
         end else if (m_held != 0) begin
            o_ev   = (m_held == 1) ? et : es;
            o_done = (m_held == 1) ? dt : ds;
            if (o_ev) begin
               m_sync = 1; m_held = 0;
            end else if (o_done) begin
               m_held = 0;
            end else if (m_age == MAX) begin
               m_to = 1; m_held = 0;
            end else begin
               m_age++;
            end
            if (m_held == 0) m_age = 0;
         end else if (ds && dt) begin
            m_fin = 1;
         end else if (es && et) begin
            m_sync = 1;
         end else if (es && !(et || dt)) begin
            m_held = 1; m_age = 1;
         end else if (et && !(es || ds)) begin
            m_held = 2; m_age = 1;
         end
         m_all = m_fin;
      end
      #1;
   endtask

   typedef struct {
      bit       r, es, et, ds, dt;
      bit [1:0] ch;
      bit       x_ss, x_st, x_sync, x_all;
      int       x_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit r, bit es, bit et, bit ds, bit dt, bit [1:0] ch,
                               bit x_ss, bit x_st, bit x_sync, int x_cnt, bit x_all);
      vec_t v;
      v.r = r; v.es = es; v.et = et; v.ds = ds; v.dt = dt; v.ch = ch;
      v.x_ss = x_ss; v.x_st = x_st; v.x_sync = x_sync; v.x_cnt = x_cnt; v.x_all = x_all;
      return v;
   endfunction

   initial begin
      int stall_cycles, max_cnt;
      bit ds_r, dt_r;
      rst_n = 0; ev_s = 0; ev_t = 0; done_s = 0; done_t = 0; choice = 0;

      //              r es et ds dt ch     ss st sy cnt all
      vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 2'b01, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 2'b10, 0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 0, 0, 2'b00, 0, 0, 1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 0, 2'b00, 1, 0, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 2'b00, 1, 0, 0, 2, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 2'b10, 1, 0, 0, 3, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 2'b00, 1, 0, 1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 1, 0, 0, 2'b00, 0, 1, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 1, 2'b01, 1, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 1, 1, 2'b00, 1, 1, 0, 0, 1));
      vecs.push_back(mk(1, 1, 1, 1, 1, 2'b00, 1, 1, 0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 0));

      foreach (vecs[i]) begin
         step(vecs[i].r, vecs[i].es, vecs[i].et, vecs[i].ds, vecs[i].dt, vecs[i].ch);
         check($sformatf("vec%0d stutter_s", i), cur_ss, vecs[i].x_ss);
         check($sformatf("vec%0d stutter_t", i), cur_st, vecs[i].x_st);
         check($sformatf("vec%0d sync_pulse", i), sync_pulse, vecs[i].x_sync);
         check($sformatf("vec%0d stall_cnt", i), stall_cnt, vecs[i].x_cnt);
         check($sformatf("vec%0d all_done", i), all_done, vecs[i].x_all);
         check($sformatf("vec%0d timeout", i), timeout, 0);
      end

      // Idle after reset: nothing moves for 20 cycles.
      for (int i = 0; i < 20; i++) begin
         step(1, 0, 0, 0, 0, 2'b00);
         check("idle stutters", {cur_ss, cur_st}, 0);
         check("idle regs", {sync_pulse, timeout, all_done, stall_cnt}, 0);
      end

      // Target runs ahead alone: forced release after MAX+1 stalled cycles.
      stall_cycles = 0; max_cnt = 0;
      step(1, 0, 1, 0, 0, 2'b00);
      if (cur_st) stall_cycles++;
      for (int i = 0; i < 15; i++) begin
         step(1, 0, 0, 0, 0, 2'b00);
         if (cur_st) stall_cycles++;
         if (int'(stall_cnt) > max_cnt) max_cnt = int'(stall_cnt);
      end
      check("timeout stall cycles", stall_cycles, MAX + 1);
      check("timeout peak stall_cnt", max_cnt, MAX);
      check("timeout sticky", timeout, 1);
      check("timeout cnt released", stall_cnt, 0);
      step(0, 0, 0, 0, 0, 2'b00);
      check("reset stutters", {cur_ss, cur_st}, 2'b11);
      check("reset clears timeout", timeout, 0);

      // Sync arriving exactly when the counter hits MAX wins over timeout.
      step(1, 1, 0, 0, 0, 2'b00);
      for (int i = 0; i < MAX - 1; i++) step(1, 0, 0, 0, 0, 2'b00);
      check("edge stall_cnt at max", stall_cnt, MAX);
      step(1, 0, 1, 0, 0, 2'b00);
      check("edge stutter_s held", cur_ss, 1);
      check("edge sync_pulse", sync_pulse, 1);
      check("edge no timeout", timeout, 0);
      check("edge cnt cleared", stall_cnt, 0);
      step(1, 0, 0, 0, 0, 2'b00);
      check("edge sync single cycle", sync_pulse, 0);

      // Randomized run against the reference model.
      ds_r = 0; dt_r = 0;
      for (int i = 0; i < 3000; i++) begin
         bit r;
         r = ($urandom_range(0, 149) != 0);
         if (!r) begin ds_r = 0; dt_r = 0; end
         else begin
            if ($urandom_range(0, 79) == 0) ds_r = 1;
            if ($urandom_range(0, 79) == 0) dt_r = 1;
         end
         step(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ds_r, dt_r,
              2'($urandom_range(0, 3)));
         check("rnd stutter_s", cur_ss, pred_ss);
         check("rnd stutter_t", cur_st, pred_st);
         check("rnd sync_pulse", sync_pulse, m_sync);
         check("rnd timeout", timeout, m_to);
         check("rnd all_done", all_done, m_all);
         check("rnd stall_cnt", stall_cnt, m_age);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
